// File: rtl/conv_pkg.sv
// Shared widths, scheduler state encoding and segment-table entry layout for
// the conv_top read scheduler.
package conv_pkg;

  localparam int unsigned ADDR_W         = 6;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned LEN_W          = 4;
  localparam int unsigned DEF_SEG_MAX    = 16;
  localparam int unsigned DEF_WAIT_W     = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    WAIT,
    READ,
    DRAIN,
    DONE
  } sched_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [LEN_W-1:0]  len;
  } seg_t;

endpackage

// File: rtl/conv_rd_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide when full.
module conv_rd_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  // Head is masked so the read port is quiet while nothing is buffered.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/conv_rd_sched.sv
// Sequences one conv_top run: kick, wait the compute latency, walk the
// segment table issuing one read per word, and return data through a FIFO.
module conv_rd_sched
  import conv_pkg::*;
#(
  parameter int unsigned SEG_MAX    = DEF_SEG_MAX,
  parameter int unsigned WAIT_W     = DEF_WAIT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(SEG_MAX)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]          cfg_start,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic [$clog2(SEG_MAX):0]   nseg,
  input  logic [WAIT_W-1:0]          wait_cyc,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       conv_en,
  output logic                       conv_read,
  output logic [ADDR_W-1:0]          conv_addr,
  input  logic [DATA_W-1:0]          conv_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready
);

  localparam int unsigned IDX_W  = $clog2(SEG_MAX);
  localparam int unsigned NSEG_W = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;

  sched_state_e      state, state_nxt;
  seg_t              tbl [SEG_MAX];
  seg_t              cur;
  logic [NSEG_W-1:0] nseg_q, nseg_nxt;
  logic [WAIT_W-1:0] wcnt_q, wcnt_nxt;
  logic [IDX_W-1:0]  seg_q, seg_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt, last_q, last_nxt, cur_addr;
  logic [LEN_W-1:0]  rem_q, rem_nxt, cur_rem;
  logic              fresh_q, fresh_nxt;
  logic              rd_q;
  logic              issue, adv, credit, drained, last_seg, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // On the first cycle of a segment the table entry is used directly, so
  // consecutive segments issue back-to-back without a load bubble.
  assign cur      = tbl[seg_q];
  assign cur_addr = fresh_q ? cur.start : addr_q;
  assign cur_rem  = fresh_q ? cur.len   : rem_q;
  assign last_seg = (NSEG_W'(seg_q) + NSEG_W'(1)) == nseg_q;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign credit    = fifo_full ? (pop & ~rd_q)
                   : (({1'b0, fifo_count} + SUM_W'(rd_q)) < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop)));
  assign drained   = ~rd_q & (fifo_empty | ((fifo_count == CNT_W'(1)) & pop));

  assign conv_read = issue;
  assign conv_addr = issue ? cur_addr : last_q;

  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) tbl[cfg_idx] <= '{start: cfg_start, len: cfg_len};
  end

  always_comb begin
    state_nxt = state;
    nseg_nxt  = nseg_q;
    wcnt_nxt  = wcnt_q;
    seg_nxt   = seg_q;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    fresh_nxt = fresh_q;
    last_nxt  = last_q;
    issue     = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = KICK;
          nseg_nxt  = nseg;
          wcnt_nxt  = wait_cyc;
        end
      end
      KICK: state_nxt = WAIT;
      WAIT: begin
        if (wcnt_q <= WAIT_W'(1)) begin
          state_nxt = (nseg_q == '0) ? DRAIN : READ;
          seg_nxt   = '0;
          fresh_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt_q - WAIT_W'(1);
        end
      end
      READ: begin
        addr_nxt  = cur_addr;
        rem_nxt   = cur_rem;
        fresh_nxt = 1'b0;
        if (cur_rem == '0) begin
          adv = 1'b1;
        end else if (credit) begin
          issue    = 1'b1;
          last_nxt = cur_addr;
          addr_nxt = cur_addr + ADDR_W'(1);
          rem_nxt  = cur_rem - LEN_W'(1);
          adv      = (cur_rem == LEN_W'(1));
        end
        if (adv) begin
          if (last_seg) begin
            state_nxt = DRAIN;
          end else begin
            seg_nxt   = seg_q + IDX_W'(1);
            fresh_nxt = 1'b1;
          end
        end
      end
      DRAIN:   if (drained) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      nseg_q  <= '0;
      wcnt_q  <= '0;
      seg_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      fresh_q <= 1'b0;
      last_q  <= '0;
      rd_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      conv_en <= 1'b0;
    end else begin
      state   <= state_nxt;
      nseg_q  <= nseg_nxt;
      wcnt_q  <= wcnt_nxt;
      seg_q   <= seg_nxt;
      addr_q  <= addr_nxt;
      rem_q   <= rem_nxt;
      fresh_q <= fresh_nxt;
      last_q  <= last_nxt;
      rd_q    <= issue;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      conv_en <= (state_nxt == KICK);
    end
  end

  conv_rd_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_q),
    .push_data (conv_data),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_conv_rd_sched.sv
// Directed bench for conv_rd_sched with a one-cycle-latency conv_top data model.
module tb_conv_rd_sched;

  logic        clk, rst_n, cfg_we, start, out_ready;
  logic        busy, done, conv_en, conv_read, out_valid;
  logic [3:0]  cfg_idx, cfg_len;
  logic [5:0]  cfg_start, conv_addr;
  logic [4:0]  nseg;
  logic [7:0]  wait_cyc;
  logic [15:0] conv_data, out_data;

  int cyc = 0;
  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [5:0]  rd_addrs[$];
  int          rd_cyc[$];
  logic [15:0] out_q[$];
  logic [5:0]  exp_q[$];
  int pop_cyc, en_n, en_cyc, done_n, done_cyc;
  int tm_start[16], tm_len[16];
  int s;

  conv_rd_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .nseg(nseg), .wait_cyc(wait_cyc),
    .start(start), .busy(busy), .done(done), .conv_en(conv_en),
    .conv_read(conv_read), .conv_addr(conv_addr), .conv_data(conv_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] dat(input logic [5:0] a);
    return 16'h5A00 | {10'd0, a};
  endfunction

  // conv_top stand-in: DATA_OUT valid the cycle after a read, junk otherwise.
  always @(posedge clk) conv_data <= conv_read ? dat(conv_addr) : 16'hDEAD;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (conv_read) begin
      rd_addrs.push_back(conv_addr);
      rd_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      pop_cyc = cyc;
    end
    if (conv_en) begin en_n++; en_cyc = cyc; end
    if (done) begin done_n++; done_cyc = cyc; end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_addrs.delete(); rd_cyc.delete(); out_q.delete();
    en_n = 0; done_n = 0; pop_cyc = 0; en_cyc = 0; done_cyc = 0;
  endtask

  task automatic write_seg(input int idx, input int st, input int len);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_start = 6'(st); cfg_len = 4'(len);
    tm_start[idx] = st; tm_len[idx] = len;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic launch(input int n, input int w, output int sc);
    clear_mon();
    nseg = 5'(n); wait_cyc = 8'(w); start = 1'b1;
    sc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (done_n > 0) ok = 1'b1;
    end
    check({tag, "_done"}, 32'(ok), 1);
  endtask

  task automatic check_seq(input string tag, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < tm_len[i]; j++) exp_q.push_back(6'((tm_start[i] + j) % 64));
    check({tag, "_nreads"}, rd_addrs.size(), exp_q.size());
    check({tag, "_nouts"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rd_addrs.size()) check($sformatf("%s_addr%0d", tag, i), rd_addrs[i], exp_q[i]);
      if (i < out_q.size())    check($sformatf("%s_data%0d", tag, i), out_q[i], dat(exp_q[i]));
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_en"}, conv_en, 0);
    check({tag, "_read"}, conv_read, 0);
    check({tag, "_addr"}, conv_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_odata"}, out_data, 0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; start = 1'b0; out_ready = 1'b1;
    cfg_idx = '0; cfg_start = '0; cfg_len = '0; nseg = '0; wait_cyc = '0;
    clear_mon();
    #12;
    check_quiet("rst");
    step(); step();
    rst_n = 1'b1;
    step();
    check_quiet("post_rst");

    // Basic run: two segments, wait 3.
    write_seg(0, 14, 7);
    write_seg(1, 55, 5);
    launch(2, 3, s);
    wait_done("t1", 100);
    check("t1_en_pulses", en_n, 1);
    check("t1_en_delay", en_cyc - s, 1);
    check("t1_rd_delay", (rd_cyc.size() > 0) ? rd_cyc[0] - s : -1, 5);
    check("t1_rd_span", (rd_cyc.size() == 12) ? rd_cyc[11] - rd_cyc[0] : -1, 11);
    check("t1_done_after_pop", done_cyc - pop_cyc, 1);
    check_seq("t1", 2);
    check("t1_busy_idle", busy, 0);

    // Address wrap with minimal wait.
    write_seg(0, 62, 4);
    launch(1, 0, s);
    wait_done("t2", 60);
    check("t2_rd_delay", (rd_cyc.size() > 0) ? rd_cyc[0] - s : -1, 3);
    check_seq("t2", 1);

    // Backpressure after the second output.
    write_seg(0, 14, 7);
    launch(2, 3, s);
    for (int i = 0; i < 50 && out_q.size() < 2; i++) step();
    out_ready = 1'b0;
    repeat (10) step();
    check("t3_stall_reads", rd_addrs.size(), 6);
    check("t3_stall_outs", out_q.size(), 2);
    check("t3_stall_valid", out_valid, 1);
    check("t3_stall_read", conv_read, 0);
    out_ready = 1'b1;
    wait_done("t3", 100);
    check_seq("t3", 2);

    // Empty run.
    launch(0, 2, s);
    wait_done("t4a", 40);
    check("t4a_nreads", rd_addrs.size(), 0);
    check("t4a_nouts", out_q.size(), 0);

    // Zero-length middle segment.
    write_seg(0, 10, 2);
    write_seg(1, 30, 0);
    write_seg(2, 40, 2);
    launch(3, 1, s);
    wait_done("t4b", 60);
    check_seq("t4b", 3);
    check("t4b_gap_in", (rd_cyc.size() == 4) ? rd_cyc[1] - rd_cyc[0] : -1, 1);
    check("t4b_gap_empty", (rd_cyc.size() == 4) ? rd_cyc[2] - rd_cyc[1] : -1, 2);

    // Start and table write while busy are ignored.
    write_seg(0, 14, 7);
    write_seg(1, 55, 5);
    launch(2, 3, s);
    step(); step();
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd0; cfg_start = 6'd33; cfg_len = 4'd2;
    nseg = 5'd1; wait_cyc = 8'd0;
    step();
    start = 1'b0; cfg_we = 1'b0;
    wait_done("t5", 100);
    check_seq("t5", 2);
    step(); step();
    check("t5_done_pulses", done_n, 1);
    check("t5_busy_idle", busy, 0);
    launch(1, 0, s);
    wait_done("t5b", 60);
    check_seq("t5b", 1);

    // Reset during READ, then a clean rerun.
    launch(2, 3, s);
    for (int i = 0; i < 50 && rd_addrs.size() < 3; i++) step();
    rst_n = 1'b0;
    #1;
    check_quiet("t6_rst");
    step(); step();
    rst_n = 1'b1;
    step();
    check("t6_no_done", done_n, 0);
    write_seg(0, 14, 7);
    write_seg(1, 55, 5);
    launch(2, 3, s);
    wait_done("t6", 100);
    check_seq("t6", 2);
    check("t6_done_pulses", done_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
